// File: rtl/man_coder_pkg.sv
// Shared types and constants for the dual-channel Manchester line encoder.
package man_coder_pkg;

    localparam int BIT_CYCLES_DEF = 6;
    localparam int CNT_W          = $clog2(BIT_CYCLES_DEF);
    localparam int HALF_DEF       = BIT_CYCLES_DEF / 2;

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic int half_cycles(input int bit_cycles);
        return bit_cycles / 2;
    endfunction

endpackage

// File: rtl/man_enc_lane.sv
// One Manchester channel: bit sample register plus registered Thomas and IEEE 802.3 outputs.
module man_enc_lane
    import man_coder_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic sample,
    input  logic first_half,
    input  logic data,
    output logic bit_nxt,
    output logic thomas,
    output logic ieee
);

    logic bit_q;

    // Next-state bit is exported so the top can register parity and differential level in step.
    assign bit_nxt = sample ? data : bit_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_q  <= 1'b0;
            thomas <= 1'b0;
            ieee   <= 1'b0;
        end else begin
            bit_q  <= bit_nxt;
            thomas <= first_half ? bit_nxt : ~bit_nxt;
            ieee   <= first_half ? ~bit_nxt : bit_nxt;
        end
    end

endmodule

// File: rtl/man_coder_top.sv
// Dual-channel Manchester encoder: bit timing, two lanes, pair parity and a channel-A
// differential-Manchester line that exists only when MAN_CODER_DIFF_EN is defined.
module man_coder_top
    import man_coder_pkg::*;
#(
    parameter int BIT_CYCLES = BIT_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic dataA,
    input  logic dataB,
    output logic out_a,
    output logic out_b,
    output logic out_top,
    output logic out_top_2,
    output logic out_top_3,
    output logic out_pin_1,
    output logic out_pin_2,
    output logic out_pin_3
);

    localparam cnt_t LAST = cnt_t'(BIT_CYCLES - 1);
    localparam cnt_t HALF = cnt_t'(half_cycles(BIT_CYCLES));

    cnt_t cnt;
    cnt_t cnt_nxt;
    logic sample;
    logic first_half_nxt;
    logic sa_nxt;
    logic sb_nxt;

    always_comb begin
        sample         = (cnt == LAST);
        cnt_nxt        = sample ? '0 : cnt + cnt_t'(1);
        first_half_nxt = (cnt_nxt < HALF);
    end

    // Outputs load from next-state values so they show the new bit right after the sample edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= LAST;
            out_top_3 <= 1'b0;
            out_pin_1 <= 1'b0;
            out_pin_3 <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            out_top_3 <= first_half_nxt;
            out_pin_1 <= (cnt_nxt == '0);
            out_pin_3 <= sa_nxt ^ sb_nxt;
        end
    end

    man_enc_lane u_lane_a (
        .clk        (clk),
        .reset      (reset),
        .sample     (sample),
        .first_half (first_half_nxt),
        .data       (dataA),
        .bit_nxt    (sa_nxt),
        .thomas     (out_a),
        .ieee       (out_top)
    );

    man_enc_lane u_lane_b (
        .clk        (clk),
        .reset      (reset),
        .sample     (sample),
        .first_half (first_half_nxt),
        .data       (dataB),
        .bit_nxt    (sb_nxt),
        .thomas     (out_b),
        .ieee       (out_top_2)
    );

`ifdef MAN_CODER_DIFF_EN
    logic diff_lvl;

    // Zero toggles at the bit boundary, every bit toggles at mid-bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            diff_lvl <= 1'b0;
        end else if (((cnt_nxt == '0) && !sa_nxt) || (cnt_nxt == HALF)) begin
            diff_lvl <= ~diff_lvl;
        end
    end

    assign out_pin_2 = diff_lvl;
`else
    assign out_pin_2 = 1'b0;
`endif

endmodule

// File: tb/tb_man_coder_top.sv
// Randomized bench for man_coder_top: per-cycle comparison against a bit-period model
// plus literal waveform expectations for the reset, startup and differential sequences.
module tb_man_coder_top;

    localparam int BC = 6;

    logic clk;
    logic reset;
    logic dataA;
    logic dataB;
    logic out_a, out_b, out_top, out_top_2, out_top_3, out_pin_1, out_pin_2, out_pin_3;
    logic [7:0] dut_vec;

    int total = 0;
    int bad   = 0;

    man_coder_top #(.BIT_CYCLES(BC)) dut (
        .clk       (clk),
        .reset     (reset),
        .dataA     (dataA),
        .dataB     (dataB),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_top   (out_top),
        .out_top_2 (out_top_2),
        .out_top_3 (out_top_3),
        .out_pin_1 (out_pin_1),
        .out_pin_2 (out_pin_2),
        .out_pin_3 (out_pin_3)
    );

    assign dut_vec = {out_a, out_b, out_top, out_top_2, out_top_3, out_pin_1, out_pin_2, out_pin_3};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: edges counted since reset release; every BC-th edge starting at the first samples the inputs.
    int   m_edges;
    logic ma, mb, mlvl;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_edges = 0;
            ma      = 1'b0;
            mb      = 1'b0;
            mlvl    = 1'b0;
        end else begin
            if ((m_edges % BC) == 0) begin
                ma = dataA;
                mb = dataB;
                if (!ma) mlvl = ~mlvl;
            end
            if ((m_edges % BC) == BC / 2) mlvl = ~mlvl;
            m_edges++;
        end
    end

    int         c_ph;
    logic       c_ta, c_tb, c_d;
    logic [7:0] c_exp;

    always @(negedge clk) begin
        if (m_edges == 0) begin
            c_exp = 8'h00;
        end else begin
            c_ph = (m_edges - 1) % BC;
            c_ta = (c_ph < BC / 2) ? ma : ~ma;
            c_tb = (c_ph < BC / 2) ? mb : ~mb;
`ifdef MAN_CODER_DIFF_EN
            c_d  = mlvl;
`else
            c_d  = 1'b0;
`endif
            c_exp = {c_ta, c_tb, ~c_ta, ~c_tb, 1'(c_ph < BC / 2), 1'(c_ph == 0), c_d, ma ^ mb};
        end
        check8("cycle_outputs", dut_vec, c_exp);
    end

    // Drives one bit with held data and checks hand-written waveforms; ed is the DIFF_EN pattern.
    task automatic lit_bit(input logic a, input logic b,
                           input logic [5:0] ea, input logic [5:0] eb, input logic [5:0] ed);
        logic ed_i;
        dataA = a;
        dataB = b;
        for (int i = 0; i < BC; i++) begin
            @(posedge clk);
            #1;
`ifdef MAN_CODER_DIFF_EN
            ed_i = ed[BC-1-i];
`else
            ed_i = 1'b0;
`endif
            check1("lit_out_a",     out_a,     ea[BC-1-i]);
            check1("lit_out_b",     out_b,     eb[BC-1-i]);
            check1("lit_out_top",   out_top,   ~ea[BC-1-i]);
            check1("lit_out_top_2", out_top_2, ~eb[BC-1-i]);
            check1("lit_out_top_3", out_top_3, 1'(i < 3));
            check1("lit_out_pin_1", out_pin_1, 1'(i == 0));
            check1("lit_out_pin_2", out_pin_2, ed_i);
            check1("lit_out_pin_3", out_pin_3, a ^ b);
            @(negedge clk);
        end
    endtask

    // One bit period: the sampled values go in before the sample edge, noise afterwards.
    task automatic step(input logic a, input logic b);
        for (int i = 0; i < BC; i++) begin
            if (i == 0) begin
                dataA = a;
                dataB = b;
            end else begin
                dataA = 1'($urandom);
                dataB = 1'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        dataA = 1'b0;
        dataB = 1'b1;
        #1 reset = 1'b0;
        #1 check8("reset_outputs", dut_vec, 8'h00);
        #4 reset = 1'b1;

        lit_bit(1'b0, 1'b1, 6'b000111, 6'b111000, 6'b111000);
        lit_bit(1'b1, 1'b0, 6'b111000, 6'b000111, 6'b000111);
        lit_bit(1'b1, 1'b0, 6'b111000, 6'b000111, 6'b111000);

        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int n = 0; n < 30; n++) step(1'($urandom), 1'($urandom));

        dataA = 1'b1;
        dataB = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1 check8("midbit_reset_outputs", dut_vec, 8'h00);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        lit_bit(1'b0, 1'b1, 6'b000111, 6'b111000, 6'b111000);
        for (int n = 0; n < 15; n++) step(1'($urandom), 1'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/man_coder_top.md
# man_coder_top

Dual-channel Manchester line encoder top level. Each clock-sampled input bit is encoded over a fixed bit period. The block drives G.E. Thomas and IEEE 802.3 encodings for two independent data channels, plus bit-timing strobes, a differential-Manchester line for channel A and a pair-parity line. It sits between the parallel data source and the line drivers. All outputs are registered and glitch-free.

## Interface
- BIT_CYCLES, 6, clock cycles per encoded bit. Must be even and ≥2. HALF = BIT_CYCLES/2.
- clk  input  1  single system clock, all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- dataA  input  1  channel A data, sampled once per bit period.
- dataB  input  1  channel B data, sampled once per bit period.
- out_a  output  1  channel A, Thomas encoding.
- out_b  output  1  channel B, Thomas encoding.
- out_top  output  1  channel A, IEEE 802.3 encoding (complement of out_a).
- out_top_2  output  1  channel B, IEEE 802.3 encoding (complement of out_b).
- out_top_3  output  1  bit clock: 1 in first half of bit, 0 in second half.
- out_pin_1  output  1  one-cycle strobe in the first cycle of each bit period.
- out_pin_2  output  1  channel A differential-Manchester line (see Configuration).
- out_pin_3  output  1  sampled dataA XOR sampled dataB, held for the whole bit.

## Operation
- Bit counter cnt runs 0..BIT_CYCLES-1 and wraps.
- Sample event: a clock edge on which cnt == BIT_CYCLES-1. On that edge:
  - latch dataA into sa and dataB into sb.
  - cnt goes to 0.
- Thomas encoding, bit 1: high for the first half, low for the second.
  - out_a = sa while cnt < HALF, else ~sa. Same rule for out_b with sb.
- IEEE outputs are the exact complement of the Thomas outputs in every cycle after reset.
- out_top_3 = (cnt < HALF).
- out_pin_1 = (cnt == 0).
- out_pin_3 = sa ^ sb.
- Differential Manchester on out_pin_2:
  - At bit start (cnt becomes 0): level toggles if sa = 0 and holds if sa = 1.
  - At mid-bit (cnt becomes HALF): level always toggles.
- Input changes between sample events have no effect. Inputs are assumed synchronous to clk.

## Timing
- While reset = 0: cnt = BIT_CYCLES-1, sa = sb = 0, every output = 0.
- The first rising edge after reset release is a sample event.
- Latency: all outputs reflect the new bit in the cycle immediately after the sample edge, because output registers are loaded from next-state values.
- The first half-bit occupies cycles cnt = 0..HALF-1 and the second occupies cnt = HALF..BIT_CYCLES-1.
- Consecutive equal bits produce a transition at the bit boundary. Alternating bits produce none at the boundary.
- Reset asserted mid-bit aborts the bit immediately and asynchronously. All outputs go to 0, and the differential level restarts at 0.

## Configuration
- MAN_CODER_DIFF_EN defined: the differential-Manchester level register and its logic drive out_pin_2.
- MAN_CODER_DIFF_EN undefined: that logic is removed and out_pin_2 is tied to 0.
- All other outputs are identical in both builds.

## Structure
- Package man_coder_pkg holds:
  - BIT_CYCLES_DEF = 6
  - the cnt_t typedef, wide enough for BIT_CYCLES-1
  - the half-period helper constant
- Sub-module man_enc_lane, instantiated once per channel:
  - holds the sample register and the Thomas and IEEE output registers.
  - inputs: sample strobe, first-half flag, data bit.
- The top holds the counter, the strobes, parity and the differential encoder.

## Test plan
- Reset low for 5 ns, then high:
  - all outputs are 0 during reset.
  - first edge samples dataA = 0, dataB = 1.
  - for 3 cycles: out_a = 0, out_b = 1, out_top = 1, out_top_2 = 0, out_pin_3 = 1.
  - then for 3 cycles: out_a = 1, out_b = 0.
- dataA = 1 held for 3 bits (18 cycles): out_a repeats 1,1,1,0,0,0 each bit, with a 0→1 edge at every boundary.
- Alternating dataA 1,0,1: out_a has no transition at bit boundaries and a transition only at mid-bit.
- Timing outputs: out_pin_1 pulses exactly every 6 cycles. out_top_3 reads 1,1,1,0,0,0 each bit.
- With MAN_CODER_DIFF_EN, dataA sequence 0,1,1 from reset:
  - out_pin_2 = 1,1,1,0,0,0 | 0,0,0,1,1,1 | 1,1,1,0,0,0.
  - without the macro, out_pin_2 stays 0.
- Reset asserted at cnt = 2 of a bit:
  - all outputs drop to 0 asynchronously.
  - after release, the first edge samples the current data again.
